// File: rtl/shared_mem_port_arbiter.sv
// shared_mem_port_arbiter
// Shares one fixed-latency memory port between the IF stage (fetch, read-only)
// and the MEM stage (load/store). Each access runs IDLE -> BUSY (WAIT_CYCLES
// cycles) -> DONE (one-cycle ready pulse) -> IDLE. Ties alternate between the
// two requesters so neither one can starve the other. The stall and freeze
// outputs hold the pipeline while a request is still outstanding.
module shared_mem_port_arbiter #(
  parameter int ADDRESS_LEN = 32,
  parameter int DATA_LEN    = 32,
  parameter int WAIT_CYCLES = 4   // legal range 1..15
) (
  input  logic                   clk,
  input  logic                   rst,
  // fetch requester
  input  logic                   if_req,
  input  logic [ADDRESS_LEN-1:0] if_addr,
  output logic [DATA_LEN-1:0]    if_rdata,
  output logic                   if_ready,
  // data requester
  input  logic                   mem_rd_req,
  input  logic                   mem_wr_req,
  input  logic [ADDRESS_LEN-1:0] mem_addr,
  input  logic [DATA_LEN-1:0]    mem_wdata,
  output logic [DATA_LEN-1:0]    mem_rdata,
  output logic                   mem_ready,
  // external memory port
  output logic                   port_en,
  output logic                   port_we,
  output logic [ADDRESS_LEN-1:0] port_addr,
  output logic [DATA_LEN-1:0]    port_wdata,
  input  logic [DATA_LEN-1:0]    port_rdata,
  // pipeline control
  output logic                   if_stall,
  output logic                   freeze
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    GR_IF  = 1'b0,
    GR_MEM = 1'b1
  } grant_t;

  // The counter counts down to zero, so a WAIT_CYCLES-cycle access loads WAIT_CYCLES-1.
  localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                 r_state;
  logic [3:0]             r_count;
  grant_t                 r_grant;
  grant_t                 r_last_grant;
  logic                   r_port_en;
  logic                   r_port_we;
  logic [ADDRESS_LEN-1:0] r_port_addr;
  logic [DATA_LEN-1:0]    r_port_wdata;
  logic [DATA_LEN-1:0]    r_if_rdata;
  logic [DATA_LEN-1:0]    r_mem_rdata;
  logic                   r_if_ready;
  logic                   r_mem_ready;

  logic                   w_mem_req;
  logic                   w_any_req;
  logic                   w_pick_mem;

  // Grant choice. A lone requester always wins. On a tie, MEM wins unless it
  // won the previous grant. last_grant resets to IF, so the first tie after
  // reset goes to MEM.
  assign w_mem_req  = mem_rd_req | mem_wr_req;
  assign w_any_req  = if_req | w_mem_req;
  assign w_pick_mem = w_mem_req & (~if_req | (r_last_grant == GR_IF));

  // Access sequencer: grant, address/data latch, wait-state countdown,
  // read-data capture and the ready pulse.
  // NOTE: every register here is updated with <=. All reads therefore see
  // pre-edge values, and the block behaves like the flops it describes.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the asynchronous reset clears the data registers as well. An aborted
    // access then leaves no stale read data and no stale port drive.
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_grant      <= GR_IF;
      r_last_grant <= GR_IF;
      r_port_en    <= 1'b0;
      r_port_we    <= 1'b0;
      r_port_addr  <= '0;
      r_port_wdata <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Requests are sampled only here. Later input changes cannot
          // disturb an access that is already running.
          if (w_any_req) begin
            r_state   <= ST_BUSY;
            r_count   <= LP_CNT_LOAD;
            r_port_en <= 1'b1;
            if (w_pick_mem) begin
              r_grant      <= GR_MEM;
              r_last_grant <= GR_MEM;
              r_port_addr  <= mem_addr;
              r_port_wdata <= mem_wdata;
              r_port_we    <= mem_wr_req;  // rd+wr together counts as a store
            end else begin
              r_grant      <= GR_IF;
              r_last_grant <= GR_IF;
              r_port_addr  <= if_addr;
              r_port_we    <= 1'b0;
            end
          end
        end

        ST_BUSY: begin
          if (r_count == 4'd0) begin
            // Last BUSY cycle: memory data is valid now, so capture it for reads.
            r_state   <= ST_DONE;
            r_port_en <= 1'b0;
            r_port_we <= 1'b0;
            if (r_grant == GR_IF) begin
              r_if_rdata <= port_rdata;
              r_if_ready <= 1'b1;
            end else begin
              if (!r_port_we) begin
                r_mem_rdata <= port_rdata;
              end
              r_mem_ready <= 1'b1;
            end
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        ST_DONE: begin
          // Requests are still high here. The next grant waits for IDLE.
          r_state     <= ST_IDLE;
          r_if_ready  <= 1'b0;
          r_mem_ready <= 1'b0;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_port_en   <= 1'b0;
          r_port_we   <= 1'b0;
          r_if_ready  <= 1'b0;
          r_mem_ready <= 1'b0;
        end
      endcase
    end
  end

  assign port_en    = r_port_en;
  assign port_we    = r_port_we;
  assign port_addr  = r_port_addr;
  assign port_wdata = r_port_wdata;
  assign if_rdata   = r_if_rdata;
  assign mem_rdata  = r_mem_rdata;
  assign if_ready   = r_if_ready;
  assign mem_ready  = r_mem_ready;

  // Pipeline hold: stay asserted until the matching ready pulse arrives.
  assign if_stall = if_req & ~r_if_ready;
  assign freeze   = w_mem_req & ~r_mem_ready;

endmodule

// File: tb/tb_shared_mem_port_arbiter.sv
// Testbench for shared_mem_port_arbiter.
// A transaction-level scheduler predicts when each grant, BUSY window and ready
// pulse occurs. It uses the access timing rules and the tie-alternation rule.
// A separate reference memory predicts the read data.
// A second instance with WAIT_CYCLES=1 covers the shortest access.
module tb_shared_mem_port_arbiter;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // main instance (WAIT_CYCLES = 4)
  logic        if_req, if_ready, mem_rd_req, mem_wr_req, mem_ready;
  logic        port_en, port_we, if_stall, freeze;
  logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] port_addr, port_wdata, port_rdata;

  // memory behind the main instance; only the main initial block writes it
  logic [31:0] mem_arr [256];
  assign port_rdata = mem_arr[port_addr[9:2]];

  shared_mem_port_arbiter #(.ADDRESS_LEN(32), .DATA_LEN(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .port_en(port_en), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_rdata(port_rdata),
    .if_stall(if_stall), .freeze(freeze)
  );

  // second instance (WAIT_CYCLES = 1)
  logic        d1_if_req, d1_if_ready, d1_mem_rd_req, d1_mem_wr_req, d1_mem_ready;
  logic        d1_port_en, d1_port_we, d1_if_stall, d1_freeze;
  logic [31:0] d1_if_addr, d1_if_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
  logic [31:0] d1_port_addr, d1_port_wdata, d1_port_rdata;
  assign d1_port_rdata = (d1_port_addr == 32'h40) ? 32'h12345678 : 32'h0;

  shared_mem_port_arbiter #(.ADDRESS_LEN(32), .DATA_LEN(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(d1_if_req), .if_addr(d1_if_addr), .if_rdata(d1_if_rdata), .if_ready(d1_if_ready),
    .mem_rd_req(d1_mem_rd_req), .mem_wr_req(d1_mem_wr_req), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata), .mem_ready(d1_mem_ready),
    .port_en(d1_port_en), .port_we(d1_port_we), .port_addr(d1_port_addr),
    .port_wdata(d1_port_wdata), .port_rdata(d1_port_rdata),
    .if_stall(d1_if_stall), .freeze(d1_freeze)
  );

  // reference state
  logic [31:0] ref_mem [256];
  logic [31:0] exp_if_rdata, exp_mem_rdata;
  bit          ref_last_mem;   // 0: last grant went to IF

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req = 1'b0; mem_rd_req = 1'b0; mem_wr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1 ("rst_port_en",    port_en,    1'b0);
    check1 ("rst_port_we",    port_we,    1'b0);
    check32("rst_port_addr",  port_addr,  32'h0);
    check32("rst_port_wdata", port_wdata, 32'h0);
    check32("rst_if_rdata",   if_rdata,   32'h0);
    check32("rst_mem_rdata",  mem_rdata,  32'h0);
    check1 ("rst_if_ready",   if_ready,   1'b0);
    check1 ("rst_mem_ready",  mem_ready,  1'b0);
    check1 ("rst_if_stall",   if_stall,   1'b0);
    rst = 1'b1;
    ref_last_mem  = 1'b0;
    exp_if_rdata  = 32'h0;
    exp_mem_rdata = 32'h0;
    @(posedge clk);
    #1;
  endtask

  // Runs n_if fetches and n_mem data accesses against the main instance.
  // Must be entered #1 after a rising edge with the arbiter idle.
  // kind: 0 random, 1 load, 2 store, 3 rd+wr together.
  // gaps=0 re-raises a request in the same cycle its ready pulse arrives.
  task automatic run_traffic(input int n_if, input int n_mem, input int kind, input bit gaps,
                             input bit rnd, input logic [31:0] fix_if_a,
                             input logic [31:0] fix_mem_a, input logic [31:0] fix_mem_d);
    int cyc = 0;
    int free_at = 0;
    int grant_cyc = -100;
    int ready_at = -100;
    int if_start = 0;
    int if_left = n_if;
    int mem_left = n_mem;
    int budget;
    int k;
    bit if_pend = 1'b0, mem_pend = 1'b0;
    bit cur_valid = 1'b0, cur_mem = 1'b0, cur_we = 1'b0;
    bit busy, exp_ifr, exp_memr;
    logic [31:0] cur_addr = 32'h0, cur_wdata = 32'h0;
    budget = (n_if + n_mem) * (W + 2) * 4 + 40;
    while ((if_left > 0 || mem_left > 0 || if_pend || mem_pend) && cyc < budget) begin
      busy     = cur_valid && cyc > grant_cyc && cyc <= grant_cyc + W;
      exp_ifr  = cur_valid && !cur_mem && cyc == ready_at;
      exp_memr = cur_valid &&  cur_mem && cyc == ready_at;
      // the memory commits writes it sees on the port
      if (port_en && port_we) mem_arr[port_addr[9:2]] = port_wdata;

      check1("port_en", port_en, busy);
      if (busy) begin
        check32("port_addr", port_addr, cur_addr);
        check1 ("port_we",   port_we,   cur_we);
        if (cur_we) check32("port_wdata", port_wdata, cur_wdata);
      end
      check1("if_ready",  if_ready,  exp_ifr);
      check1("mem_ready", mem_ready, exp_memr);

      if (exp_ifr) begin
        exp_if_rdata = ref_mem[cur_addr[9:2]];
        check1("if_latency_bound", (cyc - if_start) <= 2 * (W + 2), 1'b1);
        if_pend = 1'b0;
        if_req  = 1'b0;
      end
      if (exp_memr) begin
        if (cur_we) ref_mem[cur_addr[9:2]] = cur_wdata;
        else        exp_mem_rdata = ref_mem[cur_addr[9:2]];
        mem_pend   = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
      end
      if (exp_ifr || exp_memr) begin
        check32("if_rdata",  if_rdata,  exp_if_rdata);
        check32("mem_rdata", mem_rdata, exp_mem_rdata);
      end

      // requester agents
      if (!if_pend && if_left > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
        if_pend  = 1'b1;
        if_left--;
        if_req   = 1'b1;
        if_addr  = rnd ? {22'd0, 8'($urandom_range(0, 255)), 2'b00} : fix_if_a;
        if_start = cyc;
      end else if (!if_pend) begin
        if_addr = $urandom;
      end
      if (!mem_pend && mem_left > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
        mem_pend = 1'b1;
        mem_left--;
        k = (kind == 0) ? int'($urandom_range(1, 3)) : kind;
        mem_rd_req = (k != 2);
        mem_wr_req = (k != 1);
        mem_addr   = rnd ? {22'd0, 8'($urandom_range(0, 255)), 2'b00} : fix_mem_a;
        mem_wdata  = rnd ? $urandom : fix_mem_d;
      end else if (!mem_pend) begin
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end

      // scheduler: the arbiter samples requests only when it is free
      if (cyc == free_at) begin
        if (if_req || mem_rd_req || mem_wr_req) begin
          if (if_req && (mem_rd_req || mem_wr_req)) cur_mem = !ref_last_mem;
          else                                      cur_mem = !if_req;
          ref_last_mem = cur_mem;
          cur_valid = 1'b1;
          cur_addr  = cur_mem ? mem_addr : if_addr;
          cur_we    = cur_mem && mem_wr_req;
          cur_wdata = mem_wdata;
          grant_cyc = cyc;
          ready_at  = cyc + W + 1;
          free_at   = cyc + W + 2;
        end else begin
          free_at = cyc + 1;
        end
      end

      #1;
      check1("if_stall", if_stall, if_req && !exp_ifr);
      check1("freeze",   freeze,   (mem_rd_req || mem_wr_req) && !exp_memr);
      @(posedge clk);
      #1;
      cyc++;
    end
    check1("traffic_complete",
           (if_left == 0 && mem_left == 0 && !if_pend && !mem_pend), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    mem_rd_req = 1'b0; mem_wr_req = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    d1_if_req = 1'b0; d1_if_addr = 32'h0;
    d1_mem_rd_req = 1'b0; d1_mem_wr_req = 1'b0; d1_mem_addr = 32'h0; d1_mem_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8'h40] = 32'hE3A01005;   // word at 0x100
    ref_mem[8'h40] = 32'hE3A01005;

    // step 1: reset values
    do_reset();

    // step 2: a single fetch from 0x100
    run_traffic(1, 0, 1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0);

    // step 3: store 0xDEADBEEF to 0x20, then load it back
    run_traffic(0, 1, 2, 1'b0, 1'b0, 32'h0, 32'h20, 32'hDEADBEEF);
    run_traffic(0, 1, 1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0);

    // step 4: a tie straight after reset goes to MEM, and so does the next tie
    do_reset();
    run_traffic(1, 1, 1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0);
    run_traffic(1, 1, 1, 1'b0, 1'b0, 32'h104, 32'h24, 32'h0);

    // step 5: continuous loads with a fetch held: grants alternate
    run_traffic(2, 3, 1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);

    // step 6: rd+wr together acts as a store; mem_rdata is unchanged
    run_traffic(0, 1, 3, 1'b0, 1'b0, 32'h0, 32'h30, 32'hCAFEF00D);
    run_traffic(0, 1, 1, 1'b0, 1'b0, 32'h0, 32'h30, 32'h0);

    // step 7: randomized mixed traffic, with gaps and then back-to-back
    run_traffic(20, 20, 0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
    run_traffic(10, 10, 0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);

    // step 8: reset in the 2nd BUSY cycle of a load aborts it
    mem_rd_req = 1'b1; mem_wr_req = 1'b0; mem_addr = 32'h80;
    @(posedge clk); #1;
    check1("abort_busy1_port_en", port_en, 1'b1);
    @(posedge clk); #1;
    check1 ("abort_busy2_port_en",   port_en,   1'b1);
    check32("abort_busy2_port_addr", port_addr, 32'h80);
    #2 rst = 1'b0;
    #1;
    check1 ("abort_port_en",    port_en,    1'b0);
    check1 ("abort_port_we",    port_we,    1'b0);
    check32("abort_port_addr",  port_addr,  32'h0);
    check32("abort_port_wdata", port_wdata, 32'h0);
    check32("abort_if_rdata",   if_rdata,   32'h0);
    check32("abort_mem_rdata",  mem_rdata,  32'h0);
    check1 ("abort_if_ready",   if_ready,   1'b0);
    check1 ("abort_mem_ready",  mem_ready,  1'b0);
    @(posedge clk); #1;
    check1("abort_no_ready", mem_ready, 1'b0);
    rst = 1'b1;
    ref_last_mem  = 1'b0;
    exp_if_rdata  = 32'h0;
    exp_mem_rdata = 32'h0;
    #1;
    run_traffic(0, 1, 1, 1'b0, 1'b0, 32'h0, 32'h80, 32'h0);

    // step 9: WAIT_CYCLES=1 instance, load from 0x40
    d1_mem_rd_req = 1'b1; d1_mem_addr = 32'h40;
    #1;
    check1("w1_idle_port_en", d1_port_en, 1'b0);
    check1("w1_freeze",       d1_freeze,  1'b1);
    @(posedge clk); #1;
    check1 ("w1_busy_port_en",   d1_port_en,   1'b1);
    check32("w1_busy_port_addr", d1_port_addr, 32'h40);
    check1 ("w1_busy_port_we",   d1_port_we,   1'b0);
    check1 ("w1_busy_mem_ready", d1_mem_ready, 1'b0);
    @(posedge clk); #1;
    check1 ("w1_done_mem_ready", d1_mem_ready, 1'b1);
    check32("w1_done_mem_rdata", d1_mem_rdata, 32'h12345678);
    check1 ("w1_done_port_en",   d1_port_en,   1'b0);
    check1 ("w1_done_freeze",    d1_freeze,    1'b0);
    d1_mem_rd_req = 1'b0;
    @(posedge clk); #1;
    check1 ("w1_idle_mem_ready", d1_mem_ready, 1'b0);
    check32("w1_hold_mem_rdata", d1_mem_rdata, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
